// File: rtl/maxnet_act_bank.sv
// Maxnet activation bank: ReLU-on-write registers, iteration counter and
// registered termination/winner status derived from the post-write values.
module maxnet_act_bank #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int MAX_ITER = 63,
  parameter int IW       = 6,
  parameter int LW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_x,
  input  logic [N*W-1:0]  x_in,
  input  logic            load_a,
  input  logic            load_sel,
  input  logic [N*W-1:0]  a_next,
  output logic [N*W-1:0]  a_out,
  output logic            isfinished,
  output logic            winner_valid,
  output logic [LW-1:0]   winner_idx,
  output logic            timeout,
  output logic [IW-1:0]   iter_cnt
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0][W-1:0] a_reg_q, a_reg_d;
  logic [IW-1:0]       iter_cnt_q, iter_cnt_d;
  logic                isfinished_q, isfinished_d;
  logic                winner_valid_q, winner_valid_d;
  logic [LW-1:0]       winner_idx_q, winner_idx_d;
  logic                timeout_q, timeout_d;
  logic [CW-1:0]       pos_cnt;
  logic [LW-1:0]       low_idx;

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
    return v[W-1] ? '0 : v;
  endfunction

  always_comb begin
    a_reg_d        = a_reg_q;
    iter_cnt_d     = iter_cnt_q;
    isfinished_d   = isfinished_q;
    winner_valid_d = winner_valid_q;
    winner_idx_d   = winner_idx_q;
    timeout_d      = timeout_q;
    pos_cnt        = '0;
    low_idx        = '0;

    if (init_x) begin
      for (int i = 0; i < N; i++) a_reg_d[i] = relu(x_in[i*W +: W]);
      iter_cnt_d = '0;
    end else if (load_a) begin
      for (int i = 0; i < N; i++)
        a_reg_d[i] = relu(load_sel ? x_in[i*W +: W] : a_next[i*W +: W]);
      iter_cnt_d = (iter_cnt_q >= IW'(MAX_ITER)) ? IW'(MAX_ITER) : iter_cnt_q + IW'(1);
    end

    // Descending scan so the last hit left in low_idx is the lowest positive neuron.
    for (int i = N - 1; i >= 0; i--) begin
      if (a_reg_d[i] != '0) begin
        pos_cnt = pos_cnt + CW'(1);
        low_idx = LW'(i);
      end
    end

    if (init_x || load_a) begin
      winner_valid_d = (pos_cnt == CW'(1));
      winner_idx_d   = low_idx;
      timeout_d      = !init_x && (pos_cnt > CW'(1)) && (iter_cnt_d == IW'(MAX_ITER));
      isfinished_d   = (pos_cnt <= CW'(1)) || timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg_q        <= '0;
      iter_cnt_q     <= '0;
      isfinished_q   <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_idx_q   <= '0;
      timeout_q      <= 1'b0;
    end else begin
      a_reg_q        <= a_reg_d;
      iter_cnt_q     <= iter_cnt_d;
      isfinished_q   <= isfinished_d;
      winner_valid_q <= winner_valid_d;
      winner_idx_q   <= winner_idx_d;
      timeout_q      <= timeout_d;
    end
  end

  assign a_out        = a_reg_q;
  assign isfinished   = isfinished_q;
  assign winner_valid = winner_valid_q;
  assign winner_idx   = winner_idx_q;
  assign timeout      = timeout_q;
  assign iter_cnt     = iter_cnt_q;

endmodule

// File: tb/tb_maxnet_act_bank.sv
// Directed self-checking bench for maxnet_act_bank (N=4, W=16, MAX_ITER=63).
module tb_maxnet_act_bank;

  localparam int N = 4;
  localparam int W = 16;
  localparam int MAX_ITER = 63;
  localparam int IW = 6;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            init_x;
  logic [N*W-1:0]  x_in;
  logic            load_a;
  logic            load_sel;
  logic [N*W-1:0]  a_next;
  logic [N*W-1:0]  a_out;
  logic            isfinished;
  logic            winner_valid;
  logic [LW-1:0]   winner_idx;
  logic            timeout;
  logic [IW-1:0]   iter_cnt;

  int checks = 0;
  int failures = 0;

  maxnet_act_bank #(.N(N), .W(W), .MAX_ITER(MAX_ITER), .IW(IW)) dut (
    .clk(clk), .rst(rst), .init_x(init_x), .x_in(x_in), .load_a(load_a),
    .load_sel(load_sel), .a_next(a_next), .a_out(a_out), .isfinished(isfinished),
    .winner_valid(winner_valid), .winner_idx(winner_idx), .timeout(timeout),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  // Neuron 0 is the first argument, stored at bits [W-1:0].
  function automatic logic [N*W-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    return {v3[15:0], v2[15:0], v1[15:0], v0[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then samples #1 after the rising edge.
  task automatic applyStimulus(input logic i_init, input logic i_load, input logic i_sel,
                               input logic [N*W-1:0] i_x, input logic [N*W-1:0] i_next);
    init_x   = i_init;
    load_a   = i_load;
    load_sel = i_sel;
    x_in     = i_x;
    a_next   = i_next;
    @(posedge clk);
    #1;
  endtask

  task automatic checkStatus(input string tag, input logic fin, input logic wv,
                             input logic [LW-1:0] wi, input logic to, input int it);
    checkOutput({tag, "_isfinished"}, 64'(isfinished), 64'(fin));
    checkOutput({tag, "_winner_valid"}, 64'(winner_valid), 64'(wv));
    checkOutput({tag, "_winner_idx"}, 64'(winner_idx), 64'(wi));
    checkOutput({tag, "_timeout"}, 64'(timeout), 64'(to));
    checkOutput({tag, "_iter_cnt"}, 64'(iter_cnt), 64'(it));
  endtask

  initial begin
    logic [N*W-1:0] rounds [3];
    logic           round_fin [3];
    logic           done;
    int             nrounds;

    // Reset while a write strobe and nonzero data are present.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    checkOutput("t1_a_out", a_out, '0);
    checkStatus("t1", 1'b0, 1'b0, 2'd0, 1'b0, 0);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, pack4(5, -3, 9, 2), '0);
    checkOutput("t2_a_out", a_out, pack4(5, 0, 9, 2));
    checkStatus("t2", 1'b0, 1'b0, 2'd0, 1'b0, 0);

    applyStimulus(1'b0, 1'b1, 1'b0, '0, pack4(-1, -8, 4, -2));
    checkOutput("t3_a_out", a_out, pack4(0, 0, 4, 0));
    checkStatus("t3", 1'b1, 1'b1, 2'd2, 1'b0, 1);

    // No strobe: everything holds even with new data on the inputs.
    applyStimulus(1'b0, 1'b0, 1'b0, pack4(1, 1, 1, 1), pack4(9, 9, 9, 9));
    checkOutput("hold_a_out", a_out, pack4(0, 0, 4, 0));
    checkStatus("hold", 1'b1, 1'b1, 2'd2, 1'b0, 1);

    // load_sel=1 takes x_in on a write-back.
    applyStimulus(1'b0, 1'b1, 1'b1, pack4(0, 3, 0, -7), pack4(9, 9, 9, 9));
    checkOutput("sel_a_out", a_out, pack4(0, 3, 0, 0));
    checkStatus("sel", 1'b1, 1'b1, 2'd1, 1'b0, 2);

    applyStimulus(1'b0, 1'b1, 1'b0, '0, pack4(-5, -1, -32768, -100));
    checkOutput("t4_a_out", a_out, '0);
    checkStatus("t4", 1'b1, 1'b0, 2'd0, 1'b0, 3);

    // Tie held until the iteration cap forces timeout.
    applyStimulus(1'b1, 1'b0, 1'b0, pack4(7, 7, 0, 0), '0);
    checkStatus("t5_init", 1'b0, 1'b0, 2'd0, 1'b0, 0);
    for (int k = 1; k <= MAX_ITER; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0, pack4(7, 7, 0, 0));
      checkOutput("t5_iter_cnt", 64'(iter_cnt), 64'(k));
      checkOutput("t5_timeout", 64'(timeout), 64'(k == MAX_ITER));
      checkOutput("t5_isfinished", 64'(isfinished), 64'(k == MAX_ITER));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0, pack4(7, 7, 0, 0));
    checkStatus("t5_sat", 1'b1, 1'b0, 2'd0, 1'b1, MAX_ITER);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, pack4(0, 5, 0, 0));
    checkOutput("t5_post_a_out", a_out, pack4(0, 5, 0, 0));
    checkStatus("t5_post1", 1'b1, 1'b1, 2'd1, 1'b0, MAX_ITER);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, pack4(3, 3, 3, 0));
    checkStatus("t5_post2", 1'b1, 1'b0, 2'd0, 1'b1, MAX_ITER);

    // init_x wins over load_a and clears the saturated iteration state.
    applyStimulus(1'b1, 1'b1, 1'b0, pack4(1, 2, 0, -4), pack4(9, 9, 9, 9));
    checkOutput("t6_a_out", a_out, pack4(1, 2, 0, 0));
    checkStatus("t6", 1'b0, 1'b0, 2'd0, 1'b0, 0);

    // Controller loop MULT-ADD-WB_ACT-CHECK until isfinished.
    rounds[0] = pack4(4, 3, 0, 0); round_fin[0] = 1'b0;
    rounds[1] = pack4(2, 1, 0, 0); round_fin[1] = 1'b0;
    rounds[2] = pack4(1, -1, 0, 0); round_fin[2] = 1'b1;
    done = 1'b0;
    nrounds = 0;
    for (int r = 0; r < 3 && !done; r++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, rounds[r]);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("ctrl_check_isfinished", 64'(isfinished), 64'(round_fin[r]));
      done = isfinished;
      nrounds++;
    end
    checkOutput("ctrl_done", 64'(done), 64'(1));
    checkOutput("ctrl_rounds", 64'(nrounds), 64'(3));
    checkStatus("ctrl_final", 1'b1, 1'b1, 2'd0, 1'b0, 3);

    // Reset dominates init_x.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, pack4(8, 8, 8, 8), '0);
    rst = 1'b0;
    checkOutput("rst_init_a_out", a_out, '0);
    checkStatus("rst_init", 1'b0, 1'b0, 2'd0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
